// File: rtl/mem_xfer_engine.sv
// mem_xfer_engine: DEPTH-word memory with a host load/readback port and a
// block-copy engine that streams LEN words out to a ready-flow-controlled
// downstream write port.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data host write port (accepted in every state)
//   rd_addr/rd_data       host readback, one-cycle registered latency
//   start/src_base/dst_base/len
//                         transfer request, captured only in IDLE
//   busy, done            engine status (busy in RD/WR, done one cycle)
//   dst_we/dst_addr/dst_data/dst_ready
//                         downstream write request with ready handshake
module mem_xfer_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    input  logic              dst_ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_cur;

    // Address sums truncate to ADDR_W bits, giving the modulo-DEPTH wrap.
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign src_addr = src_q + cnt_q[ADDR_W-1:0];
    assign dst_cur  = dst_q + cnt_q[ADDR_W-1:0];
    assign rd_data  = rd_data_q;

    // Storage is deliberately not reset; nonblocking update gives
    // read-before-write on both the host and engine read paths.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            word_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            word_q    <= word_d;
            rd_data_q <= mem_q[rd_addr];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        src_d    = src_q;
        dst_d    = dst_q;
        word_d   = word_q;
        busy     = 1'b0;
        done     = 1'b0;
        dst_we   = 1'b0;
        dst_addr = '0;
        dst_data = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_base;
                    dst_d   = dst_base;
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = (len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                busy    = 1'b1;
                word_d  = mem_q[src_addr];
                state_d = S_WR;
            end
            S_WR: begin
                busy     = 1'b1;
                dst_we   = 1'b1;
                dst_addr = dst_cur;
                dst_data = word_q;
                if (dst_ready) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_xfer_engine.sv
// tb_mem_xfer_engine: directed bench for mem_xfer_engine with a
// transaction-level model of the copy schedule and literal pins.
module tb_mem_xfer_engine;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          start;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          dst_we;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_data;
    logic          dst_ready;

    always #5 clk = ~clk;

    mem_xfer_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .dst_we   (dst_we),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .dst_ready(dst_ready)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model state: expectations for the cycle after the next edge.
    logic [DW-1:0] mdl [4];
    logic [AW-1:0] qa[$];
    logic [DW-1:0] qd[$];
    bit            chk_en = 0;
    logic          e_busy, e_done, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [DW-1:0] e_rd;
    bit            e_rd_ok;

    // Observation log of accepted words and activity counters.
    logic [AW-1:0] la[$];
    logic [DW-1:0] ld[$];
    int            lc[$];
    int            busy_cnt, done_cnt, we_cnt;

    always @(negedge clk) begin
        logic n_busy, n_done, n_we;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_data;
        if (chk_en) begin
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("done", {31'b0, done}, {31'b0, e_done});
            chk("dst_we", {31'b0, dst_we}, {31'b0, e_we});
            if (e_we) begin
                chk("dst_addr", {30'b0, dst_addr}, {30'b0, e_addr});
                chk("dst_data", {24'b0, dst_data}, {24'b0, e_data});
            end
            if (e_rd_ok) chk("rd_data", {24'b0, rd_data}, {24'b0, e_rd});
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (dst_we) we_cnt++;
        end
        if (dst_we === 1'b1 && dst_ready && !rst) begin
            la.push_back(dst_addr);
            ld.push_back(dst_data);
            lc.push_back(cyc + 1);
        end
        if (rst) begin
            qa.delete();
            qd.delete();
            e_busy  = 0;
            e_done  = 0;
            e_we    = 0;
            e_addr  = '0;
            e_data  = '0;
            e_rd    = '0;
            e_rd_ok = 1;
            chk_en  = 1;
        end else begin
            e_rd    = mdl[rd_addr];
            e_rd_ok = !$isunknown(e_rd);
            n_busy  = e_busy;
            n_done  = 0;
            n_we    = e_we;
            n_addr  = e_addr;
            n_data  = e_data;
            if (e_done) begin
                n_busy = 0;
                n_we   = 0;
            end else if (!e_busy) begin
                if (start) begin
                    for (int k = 0; k < int'(len); k++) begin
                        qa.push_back(dst_base + AW'(k));
                        qd.push_back(mdl[src_base + AW'(k)]);
                    end
                    if (len == 0) n_done = 1;
                    else begin
                        n_busy = 1;
                        n_we   = 0;
                    end
                end
            end else if (!e_we) begin
                if (qa.size() > 0) begin
                    n_we   = 1;
                    n_addr = qa[0];
                    n_data = qd[0];
                end
            end else if (dst_ready) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
                n_we = 0;
                if (qa.size() == 0) begin
                    n_busy = 0;
                    n_done = 1;
                end
            end
            e_busy = n_busy;
            e_done = n_done;
            e_we   = n_we;
            e_addr = n_addr;
            e_data = n_data;
        end
        if (wr_en) mdl[wr_addr] = wr_data;
    end

    int n0;
    int dc;
    logic [DW-1:0] vals [4];

    task automatic clear_obs();
        la.delete();
        ld.delete();
        lc.delete();
        busy_cnt = 0;
        done_cnt = 0;
        we_cnt   = 0;
    endtask

    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW:0] l);
        clear_obs();
        src_base = s;
        dst_base = d;
        len      = l;
        start    = 1'b1;
        tick();
        n0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 80) begin
            tick();
            t++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 80 cycles");
        end
        dcyc = cyc;
        tick();
    endtask

    task automatic chk_word(input int k, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int off);
        if (la.size() > k) begin
            chk($sformatf("word%0d_addr", k), {30'b0, la[k]}, {30'b0, a});
            chk($sformatf("word%0d_data", k), {24'b0, ld[k]}, {24'b0, d});
            if (off >= 0) chk($sformatf("word%0d_edge", k), lc[k] - n0, off);
        end else begin
            checks++;
            failures++;
            $display("FAIL word%0d_missing: got %0d words expected more", k, la.size());
        end
    endtask

    initial begin
        vals[0] = 8'h23;
        vals[1] = 8'h87;
        vals[2] = 8'hB7;
        vals[3] = 8'hD7;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
        start     = 1'b0;
        src_base  = '0;
        dst_base  = '0;
        len       = '0;
        dst_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_we", {31'b0, dst_we}, 0);
        chk("rst_addr", {30'b0, dst_addr}, 0);
        chk("rst_data", {24'b0, dst_data}, 0);
        chk("rst_rd", {24'b0, rd_data}, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = vals[i];
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(i);
            tick();
            chk($sformatf("load_rd%0d", i), {24'b0, rd_data}, {24'b0, vals[i]});
        end

        launch(2'd0, 2'd0, 3'd4);
        wait_done(dc);
        chk("full_done_edge", dc - n0, 8);
        chk("full_busy_cycles", busy_cnt, 8);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_words", la.size(), 4);
        chk_word(0, 2'd0, 8'h23, 2);
        chk_word(1, 2'd1, 8'h87, 4);
        chk_word(2, 2'd2, 8'hB7, 6);
        chk_word(3, 2'd3, 8'hD7, 8);

        launch(2'd3, 2'd2, 3'd3);
        wait_done(dc);
        chk("wrap_done_edge", dc - n0, 6);
        chk("wrap_words", la.size(), 3);
        chk_word(0, 2'd2, 8'hD7, 2);
        chk_word(1, 2'd3, 8'h23, 4);
        chk_word(2, 2'd0, 8'h87, 6);

        launch(2'd1, 2'd1, 3'd0);
        wait_done(dc);
        chk("len0_done_edge", dc - n0, 0);
        chk("len0_we_cycles", we_cnt, 0);
        chk("len0_busy_cycles", busy_cnt, 0);
        chk("len0_done_cnt", done_cnt, 1);

        dst_ready = 1'b0;
        launch(2'd1, 2'd3, 3'd2);
        tick();
        src_base = 2'd0;
        dst_base = 2'd0;
        len      = 3'd1;
        start    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_we", {31'b0, dst_we}, 1);
            chk("stall_addr", {30'b0, dst_addr}, 3);
            chk("stall_data", {24'b0, dst_data}, 8'h87);
        end
        start     = 1'b0;
        dst_ready = 1'b1;
        wait_done(dc);
        chk("stall_done_edge", dc - n0, 9);
        chk("stall_busy_cycles", busy_cnt, 9);
        chk("stall_done_cnt", done_cnt, 1);
        chk("stall_words", la.size(), 2);
        chk_word(0, 2'd3, 8'h87, 7);
        chk_word(1, 2'd0, 8'hB7, 9);

        launch(2'd0, 2'd0, 3'd4);
        repeat (5) tick();
        chk("pre_rst_we", {31'b0, dst_we}, 1);
        chk("pre_rst_addr", {30'b0, dst_addr}, 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_we", {31'b0, dst_we}, 0);
        rst = 1'b0;
        chk("mid_rst_words", la.size(), 2);
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(i);
            tick();
            chk($sformatf("post_rst_rd%0d", i), {24'b0, rd_data}, {24'b0, vals[i]});
        end
        launch(2'd2, 2'd1, 3'd2);
        wait_done(dc);
        chk("after_rst_done_edge", dc - n0, 4);
        chk_word(0, 2'd1, 8'hB7, 2);
        chk_word(1, 2'd2, 8'hD7, 4);

        rd_addr = 2'd3;
        wr_en   = 1'b1;
        wr_addr = 2'd3;
        wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        chk("rbw_old", {24'b0, rd_data}, 8'hD7);
        tick();
        chk("rbw_new", {24'b0, rd_data}, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
